accumulate_32: RTL and testbench

//   Sequential multi-operand adder that sits downstream of the 32-bit ripple full adder.

---
 rtl/accumulate_32.sv | 95 +++++++++
 tb/tb_accumulate_32.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/accumulate_32.sv
// Multi-operand unsigned accumulator: sums a burst of len operands taken over a
// valid/ready stream and presents the total plus a sticky carry-out until consumed.
module accumulate_32 #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_carry,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [WIDTH:0]     sum_ext;

  // One extra bit so the carry out of the top bit is captured alongside the sum.
  assign sum_ext = {1'b0, acc_q} + {1'b0, in_data};

  // Handshake flags depend on state only; the result is masked outside DONE so
  // an aborted or in-progress burst never shows a partial total.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = out_valid ? acc_q : '0;
  assign out_carry = out_valid & carry_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          carry_d = 1'b0;
          if (len != '0) begin
            remaining_d = len;
            state_d     = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d       = sum_ext[WIDTH-1:0];
          carry_d     = carry_q | sum_ext[WIDTH];
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == COUNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_accumulate_32.sv
// Bench for accumulate_32: a queue-based burst model checked every cycle, plus
// directed bursts with hand-computed totals.
module tb_accumulate_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
  logic        busy;

  accumulate_32 #(.WIDTH(32), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 waiting, 1 collecting operands, 2 result held.
  int          m_phase = 0;
  int          m_left  = 0;
  bit          m_live  = 0;
  bit          m_after_reset = 0;
  bit [31:0]   m_ops[$];

  function automatic logic [32:0] model_result();
    longint s = 0;
    bit     c = 0;
    foreach (m_ops[i]) begin
      s = s + longint'(m_ops[i]);
      if (s >= 64'h1_0000_0000) begin
        c = 1;
        s = s - 64'h1_0000_0000;
      end
    end
    return {c, s[31:0]};
  endfunction

  always @(posedge clk) begin
    m_live = 1;
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_ops.delete();
      m_after_reset = 1;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_ops.delete();
             m_after_reset = 0;
             if (len == 0) m_phase = 2;
             else begin
               m_phase = 1;
               m_left  = int'(len);
             end
           end
        1: if (in_valid) begin
             m_ops.push_back(in_data);
             m_left--;
             if (m_left == 0) m_phase = 2;
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  bit saw_ready = 0;
  logic [32:0] m_res;

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready",  64'(in_ready),  64'(m_phase == 1));
      chk("out_valid", 64'(out_valid), 64'(m_phase == 2));
      chk("busy",      64'(busy),      64'(m_phase != 0));
      if (in_ready) saw_ready = 1;
      if (m_phase == 2) begin
        m_res = model_result();
        chk("model_sum",   64'(out_sum),   64'(m_res[31:0]));
        chk("model_carry", 64'(out_carry), 64'(m_res[32]));
      end else if (m_after_reset) begin
        chk("reset_sum",   64'(out_sum),   64'd0);
        chk("reset_carry", 64'(out_carry), 64'd0);
      end
    end
  end

  task automatic start_burst(input logic [7:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input int gaps);
    repeat (gaps) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // Expects the result to be visible at the current negedge or within a bounded wait.
  task automatic wait_result(input string name, input logic [31:0] esum, input logic ecarry);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, 64'(out_valid), 64'd1);
    chk({name, "_sum"},     64'(out_sum),   64'(esum));
    chk({name, "_carry"},   64'(out_carry), 64'(ecarry));
    $display("%s: sum=%h carry=%0d (wait %0d)", name, out_sum, out_carry, n);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_sum",       64'(out_sum),   64'd0);
    $display("reset: busy=%0d out_valid=%0d sum=%h", busy, out_valid, out_sum);

    // T1: result must be visible the negedge right after the last beat.
    start_burst(8'd2);
    send(32'h0000000D, 0);
    send(32'h0000000D, 0);
    chk("t1_latency", 64'(out_valid), 64'd1);
    wait_result("t1", 32'h0000001A, 1'b0);

    start_burst(8'd2);
    send(32'hFFFFFFFF, 0);
    send(32'h00000002, 0);
    wait_result("t2", 32'h00000001, 1'b1);

    start_burst(8'd3);
    send(32'h0800010D, 0);
    send(32'h1000000D, 2);
    send(32'h00000001, 2);
    wait_result("t3", 32'h1800011B, 1'b0);

    // Sticky carry: only the middle add overflows.
    start_burst(8'd3);
    send(32'hFFFFFFFF, 0);
    send(32'h00000001, 0);
    send(32'h00000005, 1);
    wait_result("sticky", 32'h00000005, 1'b1);

    saw_ready = 0;
    start_burst(8'd0);
    chk("t4_done_next", 64'(out_valid), 64'd1);
    wait_result("t4", 32'h00000000, 1'b0);
    chk("t4_no_in_ready", 64'(saw_ready), 64'd0);

    // T5: hold result under backpressure while start is pulsed.
    start_burst(8'd1);
    send(32'h00001234, 0);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len   = 8'd3;
      @(negedge clk);
      chk("t5_hold_valid", 64'(out_valid), 64'd1);
      chk("t5_hold_sum",   64'(out_sum),   64'h1234);
      $display("t5 hold %0d: out_valid=%0d sum=%h", i, out_valid, out_sum);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t5_idle_busy",  64'(busy),      64'd0);
    chk("t5_idle_valid", 64'(out_valid), 64'd0);

    // T6: reset after one of four beats discards the burst.
    start_burst(8'd4);
    send(32'h00000007, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy",      64'(busy),      64'd0);
    chk("t6_in_ready",  64'(in_ready),  64'd0);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_sum",       64'(out_sum),   64'd0);
    chk("t6_carry",     64'(out_carry), 64'd0);
    $display("t6 reset: busy=%0d sum=%h", busy, out_sum);
    start_burst(8'd1);
    send(32'h00000005, 0);
    wait_result("t6_fresh", 32'h00000005, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
